// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit.
// Provides the opcode encodings that the PC unit decodes and the next-PC
// source select encoding driven on mux_control.
package pc_pkg;

  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_JMP  = 4'b1001;
  localparam logic [3:0] OP_JR   = 4'b1010;
  localparam logic [3:0] OP_RET  = 4'b1011;
  localparam logic [3:0] OP_CALL = 4'b1100;

  typedef enum logic [1:0] {
    SEL_RAS = 2'b00,
    SEL_IMM = 2'b01,
    SEL_REG = 2'b10,
    SEL_SEQ = 2'b11
  } sel_e;

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// Return-address stack: circular buffer with a write pointer, an occupancy
// count and sticky overflow/underflow flags.
// Ports:
//   clock, reset_n   : clock, asynchronous active-low reset
//   push, pop        : one-cycle requests (never both at once)
//   clr              : synchronous clear of the sticky flags (set wins)
//   push_data        : return address written on push
//   top              : entry just below the pointer (most recent push)
//   empty, full      : occupancy status
//   count            : occupancy, 0..RAS_DEPTH
//   overflow         : sticky, push while full
//   underflow        : sticky, pop while empty
module ras_stack #(
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned PC_WIDTH  = 16,
  localparam int unsigned PTR_W    = $clog2(RAS_DEPTH),
  localparam int unsigned CNT_W    = PTR_W + 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                push,
  input  logic                pop,
  input  logic                clr,
  input  logic [PC_WIDTH-1:0] push_data,
  output logic [PC_WIDTH-1:0] top,
  output logic                empty,
  output logic                full,
  output logic [CNT_W-1:0]    count,
  output logic                overflow,
  output logic                underflow
);

  logic [PC_WIDTH-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    top_idx;

  // Power-of-two depth lets the pointer wrap naturally.
  assign top_idx = ptr - PTR_W'(1);
  assign top     = mem[top_idx];
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(RAS_DEPTH));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < RAS_DEPTH; i++) mem[i] <= '0;
      ptr       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push) begin
        // When full the pointer sits on the oldest entry, so this write
        // overwrites it while the count saturates.
        mem[ptr] <= push_data;
        ptr      <= ptr + PTR_W'(1);
        if (!full) count <= count + CNT_W'(1);
      end else if (pop && !empty) begin
        ptr   <= top_idx;
        count <= count - CNT_W'(1);
      end
      overflow  <= (push && full)  || (overflow  && !clr);
      underflow <= (pop  && empty) || (underflow && !clr);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: owns the PC register, decodes the opcode into a
// next-PC source and manages calls/returns through an internal RAS.
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   enable         : 1 advances the PC, 0 stalls all state (flag clear honoured)
//   opcode         : opcode of the instruction at pc
//   eq_flag        : BEQ condition
//   imm_target     : target for BEQ/JMP/CALL
//   reg_target     : target for JR
//   clr_flags      : clears the sticky RAS flags
//   pc             : registered program counter
//   mux_control    : combinational next-PC source select
//   flush          : registered, high one cycle after a taken redirect
//   ras_count      : RAS occupancy
//   ras_overflow   : sticky RAS overflow
//   ras_underflow  : sticky RAS underflow
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned PC_WIDTH     = 16,
  parameter int unsigned OP_WIDTH     = 4,
  parameter int unsigned RAS_DEPTH    = 4,
  parameter int unsigned RESET_VECTOR = 0,
  parameter int unsigned PC_STEP      = 1
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic [OP_WIDTH-1:0]          opcode,
  input  logic                         eq_flag,
  input  logic [PC_WIDTH-1:0]          imm_target,
  input  logic [PC_WIDTH-1:0]          reg_target,
  input  logic                         clr_flags,
  output logic [PC_WIDTH-1:0]          pc,
  output logic [1:0]                   mux_control,
  output logic                         flush,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);

  sel_e                sel;
  logic                push;
  logic                pop;
  logic                ras_empty;
  logic                ras_full;
  logic [PC_WIDTH-1:0] ras_top;
  logic [PC_WIDTH-1:0] pc_seq;
  logic [PC_WIDTH-1:0] pc_next;

  assign pc_seq = pc + PC_WIDTH'(PC_STEP);

  always_comb begin
    sel  = SEL_SEQ;
    push = 1'b0;
    pop  = 1'b0;
    if (enable) begin
      case (opcode)
        OP_WIDTH'(OP_BEQ):  sel = eq_flag ? SEL_IMM : SEL_SEQ;
        OP_WIDTH'(OP_JMP):  sel = SEL_IMM;
        OP_WIDTH'(OP_JR):   sel = SEL_REG;
        OP_WIDTH'(OP_RET): begin
          pop = 1'b1;
          // Empty stack falls through sequentially; the RAS records underflow.
          sel = ras_empty ? SEL_SEQ : SEL_RAS;
        end
        OP_WIDTH'(OP_CALL): begin
          push = 1'b1;
          sel  = SEL_IMM;
        end
        default:            sel = SEL_SEQ;
      endcase
    end
  end

  always_comb begin
    pc_next = pc_seq;
    case (sel)
      SEL_RAS: pc_next = ras_top;
      SEL_IMM: pc_next = imm_target;
      SEL_REG: pc_next = reg_target;
      default: pc_next = pc_seq;
    endcase
  end

  assign mux_control = sel;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc    <= PC_WIDTH'(RESET_VECTOR);
      flush <= 1'b0;
    end else begin
      if (enable) pc <= pc_next;
      flush <= enable && (sel != SEL_SEQ);
    end
  end

  ras_stack #(
    .RAS_DEPTH (RAS_DEPTH),
    .PC_WIDTH  (PC_WIDTH)
  ) u_ras (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .clr       (clr_flags),
    .push_data (pc_seq),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .count     (ras_count),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

  // Full status is consumed inside the stack only.
  logic unused_full;
  assign unused_full = ras_full;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expected values.
module tb_pc_sequencer;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic [3:0]  opcode;
  logic        eq_flag;
  logic [15:0] imm_target;
  logic [15:0] reg_target;
  logic        clr_flags;
  logic [15:0] pc;
  logic [1:0]  mux_control;
  logic        flush;
  logic [2:0]  ras_count;
  logic        ras_overflow;
  logic        ras_underflow;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(
    .PC_WIDTH     (16),
    .OP_WIDTH     (4),
    .RAS_DEPTH    (4),
    .RESET_VECTOR (0),
    .PC_STEP      (1)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .enable        (enable),
    .opcode        (opcode),
    .eq_flag       (eq_flag),
    .imm_target    (imm_target),
    .reg_target    (reg_target),
    .clr_flags     (clr_flags),
    .pc            (pc),
    .mux_control   (mux_control),
    .flush         (flush),
    .ras_count     (ras_count),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    enable     = 1'b0;
    opcode     = 4'b0000;
    eq_flag    = 1'b0;
    imm_target = '0;
    reg_target = '0;
    clr_flags  = 1'b0;

    // Reset state
    step();
    step();
    check("rst_pc", pc, 0);
    check("rst_flush", flush, 0);
    check("rst_cnt", ras_count, 0);
    check("rst_ovf", ras_overflow, 0);
    check("rst_unf", ras_underflow, 0);
    #2 reset_n = 1'b1;

    // Sequential
    enable = 1'b1;
    #1 check("seq_mux", mux_control, 2'b11);
    check("seq_pc0", pc, 0);
    step(); check("seq_pc1", pc, 1);
    step(); check("seq_pc2", pc, 2);
    step(); check("seq_pc3", pc, 3); check("seq_flush", flush, 0);

    // BEQ not taken, then taken
    opcode = 4'b1000; imm_target = 16'h0040; eq_flag = 1'b0;
    #1 check("beq_nt_mux", mux_control, 2'b11);
    step(); check("beq_nt_pc", pc, 4); check("beq_nt_flush", flush, 0);
    eq_flag = 1'b1;
    #1 check("beq_t_mux", mux_control, 2'b01);
    step(); check("beq_t_pc", pc, 16'h0040); check("beq_t_flush", flush, 1);
    opcode = 4'b0000; eq_flag = 1'b0;
    step(); check("beq_after_pc", pc, 16'h0041); check("beq_after_flush", flush, 0);

    // JR under stall
    opcode = 4'b1010; reg_target = 16'h1234; enable = 1'b0;
    #1 check("stall_mux", mux_control, 2'b11);
    step(); step(); step();
    check("stall_pc", pc, 16'h0041); check("stall_flush", flush, 0);
    enable = 1'b1;
    #1 check("jr_mux", mux_control, 2'b10);
    step(); check("jr_pc", pc, 16'h1234); check("jr_flush", flush, 1);

    // Jump to 5, then nested CALL/RET
    opcode = 4'b1001; imm_target = 16'h0005;
    step(); check("jmp_pc", pc, 5);
    opcode = 4'b1100; imm_target = 16'h0100;
    #1 check("call_mux", mux_control, 2'b01);
    step(); check("call1_pc", pc, 16'h0100); check("call1_cnt", ras_count, 1);
    imm_target = 16'h0200;
    step(); check("call2_pc", pc, 16'h0200); check("call2_cnt", ras_count, 2);
    opcode = 4'b1011;
    #1 check("ret_mux", mux_control, 2'b00);
    step(); check("ret1_pc", pc, 16'h0101); check("ret1_cnt", ras_count, 1);
    check("ret1_flush", flush, 1);
    step(); check("ret2_pc", pc, 6); check("ret2_cnt", ras_count, 0);
    check("nest_ovf", ras_overflow, 0); check("nest_unf", ras_underflow, 0);

    // Overflow: 5 calls from pc=6 push 7,11,21,31,41 (7 overwritten)
    opcode = 4'b1100;
    for (int i = 1; i <= 5; i++) begin
      imm_target = 16'(i * 16);
      step();
    end
    check("ovf_pc", pc, 16'h0050);
    check("ovf_cnt", ras_count, 4);
    check("ovf_flag", ras_overflow, 1);
    opcode = 4'b1011;
    step(); check("lifo1", pc, 16'h0041); check("lifo1_cnt", ras_count, 3);
    step(); check("lifo2", pc, 16'h0031);
    step(); check("lifo3", pc, 16'h0021);
    step(); check("lifo4", pc, 16'h0011); check("lifo4_cnt", ras_count, 0);
    #1 check("unf_mux", mux_control, 2'b11);
    step(); check("unf_pc", pc, 16'h0012); check("unf_flush", flush, 0);
    check("unf_flag", ras_underflow, 1); check("unf_cnt", ras_count, 0);
    check("unf_ovf_sticky", ras_overflow, 1);

    // Clear honoured during stall
    opcode = 4'b0000; enable = 1'b0; clr_flags = 1'b1;
    step(); check("clr_ovf", ras_overflow, 0); check("clr_unf", ras_underflow, 0);
    check("clr_pc", pc, 16'h0012);

    // Set wins over clear
    enable = 1'b1; opcode = 4'b1011;
    step(); check("setwins_unf", ras_underflow, 1); check("setwins_pc", pc, 16'h0013);
    opcode = 4'b0000;
    step(); check("clr2_unf", ras_underflow, 0);
    clr_flags = 1'b0;

    // Wrap
    opcode = 4'b1001; imm_target = 16'hFFFF;
    step(); check("wrap_pre", pc, 16'hFFFF);
    opcode = 4'b0000;
    step(); check("wrap_pc", pc, 0);

    // Async reset mid-cycle after a CALL
    opcode = 4'b1100; imm_target = 16'h0300;
    step(); check("prerst_pc", pc, 16'h0300); check("prerst_cnt", ras_count, 1);
    #2 reset_n = 1'b0;
    #1 check("arst_pc", pc, 0); check("arst_cnt", ras_count, 0); check("arst_flush", flush, 0);
    #3 reset_n = 1'b1;
    opcode = 4'b0000;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter unit that owns the PC register and selects the next-PC source from the decoded opcode. It supports sequential, conditional branch, absolute jump, register jump, call and return. Call and return use an internal return-address stack (RAS). It sits between the instruction decoder/register file and instruction memory, and supersedes the combinational next-PC select.

Parameters:
PC_WIDTH, 16, width of PC, targets and RAS entries
OP_WIDTH, 4, opcode width
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)
RESET_VECTOR, 0, PC value loaded on reset
PC_STEP, 1, sequential increment

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
enable  input  1  1 = advance PC this cycle; 0 = stall (hold all state)
opcode  input  OP_WIDTH  opcode of the instruction at pc
eq_flag  input  1  equality result for BEQ
imm_target  input  PC_WIDTH  absolute target for BEQ/JMP/CALL
reg_target  input  PC_WIDTH  register-read target for JR
clr_flags  input  1  synchronous clear of sticky RAS flags
pc  output  PC_WIDTH  current program counter (registered)
mux_control  output  2  combinational next-PC source select
flush  output  1  registered; high one cycle after a taken redirect
ras_count  output  $clog2(RAS_DEPTH)+1  current RAS occupancy
ras_overflow  output  1  sticky: a push occurred while RAS full
ras_underflow  output  1  sticky: a pop occurred while RAS empty

Behaviour:
- Reset (async, reset_n=0): pc=RESET_VECTOR, flush=0, ras_count=0, RAS pointer=0, both flags=0. Takes effect immediately, mid-operation included. Release is synchronous to clock.
- Opcode decode and mux_control encoding (combinational):
  - 4'b1000 BEQ: if eq_flag=1, select 01 (imm); else 11 (sequential).
  - 4'b1001 JMP: select 01 (imm).
  - 4'b1010 JR: select 10 (reg_target).
  - 4'b1011 RET: select 00 (RAS top). Pop.
  - 4'b1100 CALL: select 01 (imm). Push pc+PC_STEP.
  - All other opcodes: select 11 (pc+PC_STEP).
- When enable=0, mux_control=2'b11. mux_control never drives X or Z.
- PC update: on a rising edge with enable=1, pc <= selected source. Single-cycle latency from opcode to new pc.
- PC arithmetic is modulo 2^PC_WIDTH: 16'hFFFF + 1 wraps to 0.
- Taken redirect is any selection other than 11. flush <= 1 for exactly one cycle after the taken edge, and 0 otherwise. When enable=0, flush <= 0.
- RAS is a circular buffer of RAS_DEPTH entries with a write pointer and occupancy count.
- Push (CALL, enable=1):
  - Write pc+PC_STEP at the pointer, then advance the pointer.
  - If count<RAS_DEPTH, count++.
  - If already full, overwrite the oldest entry, hold count at RAS_DEPTH, and set ras_overflow.
- Pop (RET, enable=1):
  - If count>0: target = entry at pointer-1, retreat the pointer, count--.
  - If count=0: target = pc+PC_STEP and mux_control forced to 11 (no redirect, no flush). Pointer and count unchanged; set ras_underflow.
- Only one opcode per cycle, so push and pop are never simultaneous.
- Stall (enable=0): pc, RAS contents, pointer, count and flags hold. clr_flags is still honoured.
- clr_flags=1 clears both sticky flags on the next edge. If clr_flags and a new overflow/underflow event occur in the same cycle, the flag ends set (set wins).

Decomposition:
- Shared package pc_pkg:
  - opcode constants OP_BEQ=4'b1000, OP_JMP=4'b1001, OP_JR=4'b1010, OP_RET=4'b1011, OP_CALL=4'b1100;
  - mux_control constants SEL_RAS=2'b00, SEL_IMM=2'b01, SEL_REG=2'b10, SEL_SEQ=2'b11.
- One sub-module: ras_stack (parametrised RAS_DEPTH, PC_WIDTH). It holds the circular buffer, pointer, count and sticky flags, with push/pop/clr inputs and top/empty/full outputs. Decode and the PC register stay in pc_sequencer.

Test Plan:
1. Reset/sequential: hold reset_n=0, then release with opcode=4'b0000, enable=1 → pc 0,1,2,3 on successive edges; flush=0; mux_control=11.
2. BEQ: opcode=4'b1000, imm_target=16'h0040, eq_flag=0 → pc advances to pc+1, no flush. Repeat with eq_flag=1 → pc=16'h0040, mux_control=01, flush high exactly one cycle.
3. JR and stall: opcode=4'b1010, reg_target=16'h1234, enable=0 for 3 cycles → pc held, mux_control=11. Then enable=1 → pc=16'h1234, mux_control=10.
4. CALL/RET nesting, RAS_DEPTH=4:
   - CALL at pc=5 to 16'h0100, then CALL at 16'h0100 to 16'h0200.
   - RET → pc=16'h0101; RET → pc=6.
   - ras_count sequence 1,2,1,0; no flags set.
5. Overflow/underflow, RAS_DEPTH=4:
   - 5 CALLs → ras_overflow=1, ras_count=4.
   - 4 RETs return the 4 newest addresses in LIFO order.
   - 5th RET → pc+1, mux_control=11, ras_underflow=1.
   - clr_flags → both flags 0.
6. Wrap and async reset: pc=16'hFFFF with sequential opcode → pc=0. Assert reset_n low mid-cycle after a CALL → pc=RESET_VECTOR and ras_count=0 immediately, without waiting for a clock edge.
